// File: rtl/ps2_keyboard_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_if
// Description : Keyboard port between the memory-mapped I/O decoder and the
//               PS/2 keyboard controller.
//                 kb_data_receive : read strobe, idles high, low during a read
//                 kb_data_ready   : character FIFO non-empty
//                 kb_ascii        : FIFO head character (0x00 when empty)
//               master = decoder side, slave = keyboard controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_keyboard_if;
    logic       kb_data_receive;
    logic       kb_data_ready;
    logic [7:0] kb_ascii;

    modport master (
        output kb_data_receive,
        input  kb_data_ready,
        input  kb_ascii
    );

    modport slave (
        input  kb_data_receive,
        output kb_data_ready,
        output kb_ascii
    );
endinterface
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard
// Description : PS/2 set-2 keyboard receiver. Synchronises and de-glitches the
//               PS/2 pins, deframes 11-bit frames, filters break (F0) and
//               extended (E0) sequences, translates make codes to ASCII and
//               buffers characters in a FIFO read by the I/O decoder.
// Ports       : clk      - system clock
//               rst      - synchronous reset, active low
//               ps2_clk  - PS/2 clock pin (asynchronous)
//               ps2_data - PS/2 data pin (asynchronous)
//               kb       - decoder port (ps2_keyboard_if.slave)
// Parameters  : FIFO_DEPTH     - FIFO entries, power of two, >= 2
//               FILTER_LEN     - equal samples needed to accept a ps2_clk level
//               TIMEOUT_CYCLES - idle clk cycles before a partial frame is dropped
// Options     : PS2_PARITY_CHECK_EN - when defined, frames with even parity
//               (over data + parity bit) are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_keyboard_if.slave     kb
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          clk_filt_q, clk_filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q, parity_d;
`endif

    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    char_q, char_d;
    logic          char_vld_q, char_vld_d;

    logic          rcv_prev_q, rcv_prev_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          fall_w;
    logic          frame_done_w;
    logic          frame_ok_w;
    logic          parity_ok_w;
    logic [8:0]    xlate_w;
    logic          pop_w;
    logic          push_w;
    logic          full_w;
    logic          empty_w;

    // Returns {hit, ascii}; hit=0 means the code has no mapping.
    function automatic logic [8:0] xlate(input logic [7:0] code);
        logic [8:0] r;
        case (code)
            8'h1C: r = {1'b1, 8'h61}; // a
            8'h32: r = {1'b1, 8'h62}; // b
            8'h21: r = {1'b1, 8'h63}; // c
            8'h23: r = {1'b1, 8'h64}; // d
            8'h24: r = {1'b1, 8'h65}; // e
            8'h2B: r = {1'b1, 8'h66}; // f
            8'h34: r = {1'b1, 8'h67}; // g
            8'h33: r = {1'b1, 8'h68}; // h
            8'h43: r = {1'b1, 8'h69}; // i
            8'h3B: r = {1'b1, 8'h6A}; // j
            8'h42: r = {1'b1, 8'h6B}; // k
            8'h4B: r = {1'b1, 8'h6C}; // l
            8'h3A: r = {1'b1, 8'h6D}; // m
            8'h31: r = {1'b1, 8'h6E}; // n
            8'h44: r = {1'b1, 8'h6F}; // o
            8'h4D: r = {1'b1, 8'h70}; // p
            8'h15: r = {1'b1, 8'h71}; // q
            8'h2D: r = {1'b1, 8'h72}; // r
            8'h1B: r = {1'b1, 8'h73}; // s
            8'h2C: r = {1'b1, 8'h74}; // t
            8'h3C: r = {1'b1, 8'h75}; // u
            8'h2A: r = {1'b1, 8'h76}; // v
            8'h1D: r = {1'b1, 8'h77}; // w
            8'h22: r = {1'b1, 8'h78}; // x
            8'h35: r = {1'b1, 8'h79}; // y
            8'h1A: r = {1'b1, 8'h7A}; // z
            8'h45: r = {1'b1, 8'h30}; // 0
            8'h16: r = {1'b1, 8'h31}; // 1
            8'h1E: r = {1'b1, 8'h32}; // 2
            8'h26: r = {1'b1, 8'h33}; // 3
            8'h25: r = {1'b1, 8'h34}; // 4
            8'h2E: r = {1'b1, 8'h35}; // 5
            8'h36: r = {1'b1, 8'h36}; // 6
            8'h3D: r = {1'b1, 8'h37}; // 7
            8'h3E: r = {1'b1, 8'h38}; // 8
            8'h46: r = {1'b1, 8'h39}; // 9
            8'h29: r = {1'b1, 8'h20}; // space
            8'h5A: r = {1'b1, 8'h0D}; // enter
            8'h66: r = {1'b1, 8'h08}; // backspace
            default: r = 9'h000;
        endcase
        return r;
    endfunction

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign parity_ok_w = ^{shift_q, parity_q};
`else
    assign parity_ok_w = 1'b1;
`endif

    assign xlate_w = xlate(shift_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Pin synchronisers
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;

        // Level filter: flip only after FILTER_LEN consecutive differing samples.
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        // Edge is flagged in the cycle the filtered level is about to drop,
        // so ps2_data is sampled alongside it.
        fall_w = clk_filt_q & ~clk_filt_d;

        // Frame deserialiser
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        to_cnt_d     = to_cnt_q;
        frame_done_w = 1'b0;
        frame_ok_w   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall_w && !dat_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall_w) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_w) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = dat_s2_q;
`endif
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_w) begin
                    frame_done_w = 1'b1;
                    frame_ok_w   = dat_s2_q & parity_ok_w;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inactivity timeout; restarts on every edge, held at zero in IDLE.
        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else if (fall_w) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d = '0;
            state_d  = ST_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        // Make/break filtering and translation; char_q is pushed next cycle.
        brk_d      = brk_q;
        ext_d      = ext_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        if (frame_done_w && frame_ok_w) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (xlate_w[8]) begin
                char_d     = xlate_w[7:0];
                char_vld_d = 1'b1;
            end
        end

        // FIFO
        rcv_prev_d = kb.kb_data_receive;
        empty_w    = (count_q == '0);
        full_w     = (count_q == CW'(FIFO_DEPTH));
        pop_w      = rcv_prev_q & ~kb.kb_data_receive & ~empty_w;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_w     = char_vld_q & (~full_w | pop_w);

        mem_d = mem_q;
        if (push_w) begin
            mem_d[wr_ptr_q] = char_q;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_w);
        rd_ptr_d = rd_ptr_q + AW'(pop_w);
        count_d  = count_q + CW'(push_w) - CW'(pop_w);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            to_cnt_q   <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            char_q     <= 8'h00;
            char_vld_q <= 1'b0;
            rcv_prev_q <= 1'b1;
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            to_cnt_q   <= to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= parity_d;
`endif
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            char_q     <= char_d;
            char_vld_q <= char_vld_d;
            rcv_prev_q <= rcv_prev_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Decoder-facing outputs
    // ------------------------------------------------------------------
    assign kb.kb_data_ready = (count_q != '0);
    assign kb.kb_ascii      = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard
// Description : Directed self-checking bench for ps2_keyboard. Drives PS/2
//               frames on the pins and reads characters through the decoder
//               interface, comparing against hand-computed ASCII values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard;

    localparam int HALF   = 20;   // clk cycles per PS/2 clock half-period
    localparam int TO_CYC = 300;

    logic clk;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    int n_checks = 0;
    int n_errors = 0;
    int lat_meas = -1;

    ps2_keyboard_if kb_if ();

    ps2_keyboard #(
        .FIFO_DEPTH    (8),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .kb      (kb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // pop_at >= 0 drops kb_data_receive after that many cycles of the stop-bit
    // low phase; measure records the first cycle ready is seen high.
    task automatic send_frame(input logic [7:0] code, input logic par, input logic stop,
                              input int pop_at, input bit measure);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        ps2_data = stop;
        cyc(HALF);
        ps2_clk = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            @(posedge clk);
            #1;
            if (measure && lat_meas < 0 && kb_if.kb_data_ready) lat_meas = k;
            if (k == pop_at) kb_if.kb_data_receive = 1'b0;
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(HALF);
        kb_if.kb_data_receive = 1'b1;
        cyc(2);
    endtask

    task automatic send_ok(input logic [7:0] code);
        send_frame(code, ~^code, 1'b1, -1, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {31'd0, kb_if.kb_data_ready}, 32'd1);
        check(tag, {24'd0, kb_if.kb_ascii}, {24'd0, exp});
        kb_if.kb_data_receive = 1'b0;
        cyc(3);
        kb_if.kb_data_receive = 1'b1;
        cyc(2);
    endtask

    task automatic check_empty(input string tag);
        check(tag, {23'd0, kb_if.kb_data_ready, kb_if.kb_ascii}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        kb_if.kb_data_receive = 1'b1;
        cyc(5);
        check_empty("reset");
        rst = 1'b1;
        cyc(5);

        // Basic character with latency measurement
        send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b1);
        check("lat_found", {31'd0, (lat_meas > 1)}, 32'd1);
        if (lat_meas < 2) lat_meas = 8;
        pop_check("basic_a", 8'h61);
        check_empty("basic_empty");

        // Break / extended filtering
        send_ok(8'h1C);
        send_ok(8'hF0);
        send_ok(8'h1C);
        send_ok(8'hE0);
        send_ok(8'h75);
        send_ok(8'hE0);
        send_ok(8'h1C);
        pop_check("brk_one", 8'h61);
        check_empty("brk_only_one");
        send_ok(8'h32);
        pop_check("flags_cleared", 8'h62);

        // Overflow: nine pushes, eight kept
        for (int i = 0; i < 9; i++) send_ok(8'h16);
        for (int i = 0; i < 8; i++) pop_check("ovf_pop", 8'h31);
        check_empty("ovf_empty");
        send_ok(8'h1E);
        send_ok(8'h26);
        send_ok(8'h25);
        pop_check("wrap_2", 8'h32);
        pop_check("wrap_3", 8'h33);
        pop_check("wrap_4", 8'h34);
        check_empty("wrap_empty");

        // Pop lands in the same cycle as a write into a full FIFO
        for (int i = 0; i < 8; i++) send_ok(8'h16);
        send_frame(8'h1E, ~^8'h1E, 1'b1, lat_meas - 1, 1'b0);
        for (int i = 0; i < 7; i++) pop_check("sim_pop", 8'h31);
        pop_check("sim_tail", 8'h32);
        check_empty("sim_empty");

        // Held read strobe pops exactly once
        send_ok(8'h1C);
        send_ok(8'h32);
        send_ok(8'h21);
        kb_if.kb_data_receive = 1'b0;
        cyc(20);
        check("hold_head", {24'd0, kb_if.kb_ascii}, 32'h62);
        kb_if.kb_data_receive = 1'b1;
        cyc(2);
        pop_check("hold_b", 8'h62);
        pop_check("hold_c", 8'h63);
        check_empty("hold_empty");

        // Bad stop bit
        send_frame(8'h1C, 1'b0, 1'b0, -1, 1'b0);
        cyc(10);
        check_empty("bad_stop");

        // Abandoned frame then timeout
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        cyc(TO_CYC + 100);
        send_ok(8'h29);
        pop_check("timeout_space", 8'h20);
        check_empty("timeout_empty");

        // Wrong parity bit
        send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check_empty("parity_drop");
`else
        pop_check("parity_ignored", 8'h61);
`endif
        check_empty("parity_empty");

        // Reset mid-frame with characters queued
        send_ok(8'h1C);
        send_ok(8'h32);
        check("rst_queued", {31'd0, kb_if.kb_data_ready}, 32'd1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check_empty("rst_mid");
        cyc(50);
        send_ok(8'h5A);
        pop_check("rst_enter", 8'h0D);
        check_empty("final_empty");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard.md
# ps2_keyboard

Keyboard input controller that sits directly downstream of the memory-mapped I/O decoder's keyboard port. It receives PS/2 set-2 scan-code frames, filters make/break sequences, translates make codes to ASCII, and buffers characters in a small FIFO. The decoder reads the head character and status through `kb_ascii` and `kb_data_ready`, and pops with `kb_data_receive`.

## Interface
- `FIFO_DEPTH`, default 8: character FIFO entries; power of two, at least 2.
- `FILTER_LEN`, default 4: number of consecutive equal samples needed to accept a new `ps2_clk` level.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is abandoned.
- `clk` input 1: system clock. One clock domain for the whole block.
- `rst` input 1: reset, synchronous, active-low.
- `ps2_clk` input 1: PS/2 clock; asynchronous; passes through a 2-flop synchronizer.
- `ps2_data` input 1: PS/2 data; asynchronous; passes through a 2-flop synchronizer.
- `kb_data_receive` input 1: read strobe from the decoder. Idles high and is held low for the whole read access.
- `kb_data_ready` output 1: high while the FIFO is non-empty.
- `kb_ascii` output 8: FIFO head character; 0x00 when the FIFO is empty.

## Operation
- **Reset values:** `kb_data_ready`=0, `kb_ascii`=0x00, FIFO empty, frame FSM in IDLE, break/ext flags cleared, previous-`kb_data_receive` register=1, filtered `ps2_clk`=1.
- **Edge detection:** a frame edge is a 1→0 transition of the filtered `ps2_clk`. `ps2_data` is sampled in the same cycle the edge is detected.
- **Frame FSM, IDLE:**
  - Start bit = 0 → DATA, bit count 0.
  - Start bit = 1 → stay in IDLE.
- **Frame FSM, DATA:** eight bits, LSB first, shifted into the code register, then → PARITY.
- **Frame FSM, PARITY:** store the parity bit, then → STOP.
- **Frame FSM, STOP:**
  - Stop bit = 1 → frame valid.
  - Stop bit = 0 → frame discarded.
  - Either way → IDLE.
- **Timeout:** in any state other than IDLE, `TIMEOUT_CYCLES` without an edge → IDLE, partial frame discarded. The timeout counter restarts on every edge.
- **Code handling for a valid frame:**
  - 0xF0: set break flag; emit nothing.
  - 0xE0: set ext flag; emit nothing.
  - Any other code with break or ext set: discarded; both flags cleared.
  - Any other code otherwise: translated to ASCII.
- **Translation table:**
  - Letters map to lowercase: 0x1C→0x61 'a', 0x32→'b', 0x21→'c', 0x23→'d', 0x24→'e', and so on through the full set-2 letter map.
  - Digits: 0x45→'0', 0x16→'1' … 0x46→'9'.
  - 0x29→0x20 (space), 0x5A→0x0D (enter), 0x66→0x08 (backspace).
  - Any other code: dropped.
- **FIFO push:** each translated character is pushed. A push while full drops the new character; FIFO contents are unchanged.
- **FIFO pop:** occurs on the 1→0 transition of `kb_data_receive`, detected against the registered previous value. Holding it low for many cycles pops exactly once. A pop while empty is ignored.
- **Simultaneous push and pop:** both take effect; occupancy is unchanged. If the FIFO was full, the push is accepted because the pop frees a slot in the same cycle.
- **Pointers:** wrap modulo `FIFO_DEPTH`. Occupancy counter is log2(`FIFO_DEPTH`)+1 bits wide.

## Timing
- **Input path latency:** 2 synchronizer cycles plus `FILTER_LEN` cycles from a pin change to the filtered level change.
- **Character latency:**
  - Cycle N: stop-bit edge detected.
  - Cycle N+1: translated character registered; FIFO write occurs at the end of N+1.
  - Cycle N+2: `kb_data_ready`/`kb_ascii` reflect it.
- **Read latency:** `kb_ascii` is valid combinationally from the FIFO head register path; it is stable whenever `kb_data_ready`=1.
- **After a pop:** falling edge of `kb_data_receive` sampled at cycle M; head advances at the end of M; new `kb_ascii`/`kb_data_ready` visible at M+1.
- **Decoder interaction:** the decoder samples `kb_ascii` while `kb_data_receive` is low. Because the pop lands one cycle later, the decoder captures the pre-pop value in the first cycle of the access.
- **Reset mid-frame or mid-read:** FSM, flags and FIFO clear on the next `clk` edge; nothing is emitted.

## Configuration
- **`PS2_PARITY_CHECK_EN` defined:** the frame is valid only if the 8 data bits plus the parity bit contain an odd number of ones. A parity failure discards the frame and leaves the break/ext flags untouched.
- **`PS2_PARITY_CHECK_EN` undefined:** the parity bit is sampled and ignored. Validity depends only on the stop bit.

## Test plan
- **Basic character:** frame 0x1C (parity 0, stop 1) → `kb_data_ready`=1 and `kb_ascii`=0x61 two cycles after the stop edge; pop → ready=0, ascii=0x00.
- **Break filtering:** frames 0x1C, 0xF0, 0x1C → exactly one 0x61 in the FIFO; the extended sequence 0xE0, 0x75 → nothing.
- **Overflow and wrap:** 9 frames of 0x16 with depth 8 → 8 entries of 0x31; 8 pops return 0x31 each; ready=0 after the 8th. Then push 3 more and pop 3 to exercise pointer wrap.
- **Simultaneous events and held read:** pop edge in the same cycle as a FIFO write while full → occupancy stays 8 and the new char is at the tail. `kb_data_receive` held low 20 cycles → exactly one pop.
- **Error frames:** stop bit = 0 → discarded. Frame abandoned after 4 bits, then `TIMEOUT_CYCLES` idle → FSM back in IDLE, and the next full 0x29 frame yields 0x20. With `PS2_PARITY_CHECK_EN`, 0x1C sent with parity 1 → discarded; without the macro → 0x61.
- **Reset mid-frame:** assert `rst`=0 for one cycle mid-frame with 2 chars queued → ready=0, ascii=0x00. The next full frame 0x5A yields 0x0D.
